// File: rtl/shifter_pkg.sv
// Shared types and defaults for the operand-2 shifter.
// The fill selection maps each shift type onto the single right-shift chain.
package shifter_pkg;

  localparam int SHIFTER_WIDTH   = 32;
  localparam int SHIFTER_SHAMT_W = 5;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_type_e;

  typedef enum logic [1:0] {
    FILL_ZERO = 2'b00,
    FILL_SIGN = 2'b01,
    FILL_WRAP = 2'b10
  } fill_e;

  // LSL runs on the bit-reversed operand, so it needs zero fill like LSR.
  function automatic fill_e fill_for(input shift_type_e st);
    case (st)
      SH_ASR:  fill_for = FILL_SIGN;
      SH_ROR:  fill_for = FILL_WRAP;
      default: fill_for = FILL_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/shifter_core.sv
// Combinational log2 barrel shifter: one right-shift stage chain with a
// selectable fill source; LSL reverses bits around the same chain.
module shifter_core
  import shifter_pkg::*;
#(
  parameter int WIDTH   = SHIFTER_WIDTH,
  parameter int SHAMT_W = SHIFTER_SHAMT_W
) (
  input  logic [WIDTH-1:0]   rd2,
  input  logic [SHAMT_W-1:0] shift_amount,
  input  shift_type_e        shift_type,
  output logic [WIDTH-1:0]   result
);

  fill_e            fill_sel;
  logic             reverse;
  logic             sign;
  logic [WIDTH-1:0] rd2_rev;
  logic [WIDTH-1:0] chain_in;
  logic [WIDTH-1:0] chain_out;
  logic [WIDTH-1:0] chain_rev;

  assign fill_sel = fill_for(shift_type);
  assign reverse  = (shift_type == SH_LSL);
  assign sign     = (fill_sel == FILL_SIGN) && rd2[WIDTH-1];

  for (genvar i = 0; i < WIDTH; i++) begin : g_rev
    assign rd2_rev[i]   = rd2[WIDTH-1-i];
    assign chain_rev[i] = chain_out[WIDTH-1-i];
  end

  assign chain_in = reverse ? rd2_rev : rd2;

  // Stage k shifts right by 2**k; wrap fill takes the bits falling off the
  // bottom, so a zero shift amount never asks for a WIDTH-bit shift.
  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    localparam int S = 1 << k;
    logic [WIDTH-1:0] in_w;
    logic [WIDTH-1:0] out_w;
    logic [S-1:0]     fill;

    if (k == 0) begin : g_first
      assign in_w = chain_in;
    end else begin : g_next
      assign in_w = g_stage[k-1].out_w;
    end

    always_comb begin
      case (fill_sel)
        FILL_WRAP: fill = in_w[S-1:0];
        FILL_SIGN: fill = {S{sign}};
        default:   fill = '0;
      endcase
    end

    assign out_w = shift_amount[k] ? {fill, in_w[WIDTH-1:S]} : in_w;
  end

  assign chain_out = g_stage[SHAMT_W-1].out_w;
  assign result    = reverse ? chain_rev : chain_out;

endmodule

// File: rtl/shifter.sv
// Operand-2 shifter: multiply bypass plus a registered barrel shift result.
// No handshake: one operation is accepted every cycle, result one cycle later.
module shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH   = SHIFTER_WIDTH,
  parameter int SHAMT_W = SHIFTER_SHAMT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SHAMT_W-1:0] shift_amount,
  input  logic [1:0]         shift_type,
  input  logic               mul,
  input  logic [WIDTH-1:0]   rd2,
  output logic [WIDTH-1:0]   data
);

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] data_next;

  shifter_core #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_core (
    .rd2          (rd2),
    .shift_amount (shift_amount),
    .shift_type   (shift_type_e'(shift_type)),
    .result       (shifted)
  );

  assign data_next = mul ? rd2 : shifted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else begin
      data <= data_next;
    end
  end

endmodule

// File: tb/tb_shifter.sv
// Randomized and directed bench for shifter with a queue-based scoreboard.
module tb_shifter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [4:0]   shift_amount;
  logic [1:0]   shift_type;
  logic         mul;
  logic [W-1:0] rd2;
  logic [W-1:0] data;

  logic         drv_vld = 1'b0;
  logic         mon_vld;

  logic [W-1:0] exp_q[$];
  string        name_q[$];

  int checks = 0;
  int passes = 0;

  shifter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .shift_amount (shift_amount),
    .shift_type   (shift_type),
    .mul          (mul),
    .rd2          (rd2),
    .data         (data)
  );

  // Clock and reset-aware issue tracking
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mon_vld <= 1'b0;
    else        mon_vld <= drv_vld;
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  // Reference model from the operation definitions
  function automatic logic [W-1:0] model(input logic [W-1:0] x, input int amt,
                                         input logic [1:0] t, input logic m);
    logic [2*W-1:0] wide;
    if (m) return x;
    case (t)
      2'b00: begin wide = {{W{1'b0}}, x} << amt; return wide[W-1:0]; end
      2'b01: return x >> amt;
      2'b10: return $signed(x) >>> amt;
      default: begin wide = {x, x} >> amt; return wide[W-1:0]; end
    endcase
  endfunction

  // Driver
  task automatic issue(input string name, input logic [W-1:0] x, input int amt,
                       input logic [1:0] t, input logic m);
    @(negedge clk);
    rd2          = x;
    shift_amount = amt[4:0];
    shift_type   = t;
    mul          = m;
    drv_vld      = 1'b1;
    exp_q.push_back(model(x, amt, t, m));
    name_q.push_back(name);
  endtask

  task automatic issue_exp(input string name, input logic [W-1:0] x, input int amt,
                           input logic [1:0] t, input logic m, input logic [W-1:0] e);
    issue(name, x, amt, t, m);
    // Directed vectors also pin the model against hand-derived values.
    check({name, "_model"}, exp_q[$], e);
  endtask

  task automatic idle();
    @(negedge clk);
    drv_vld = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    idle();
    while (exp_q.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue_empty", W'(exp_q.size()), '0);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n && mon_vld) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_output: got %08h expected no output", data);
      end else begin
        logic [W-1:0] e;
        string        n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check(n, data, e);
      end
    end
  end

  initial begin
    rst_n        = 1'b0;
    rd2          = $urandom();
    shift_amount = 5'($urandom_range(0, 31));
    shift_type   = 2'($urandom_range(0, 3));
    mul          = 1'b1;
    #1;
    check("reset_before_clk", data, '0);
    repeat (3) @(negedge clk);
    check("reset_held", data, '0);
    rst_n = 1'b1;

    issue_exp("lsl_ff_2",      32'h000000FF, 2,  2'b00, 1'b0, 32'h000003FC);
    issue_exp("lsr_fill",      32'hF000000F, 3,  2'b01, 1'b0, 32'h1E000001);
    issue_exp("asr_neg",       32'h80000000, 4,  2'b10, 1'b0, 32'hF8000000);
    issue_exp("asr_pos",       32'h7F000000, 4,  2'b10, 1'b0, 32'h07F00000);
    issue_exp("mul_ror0",      32'h12345678, 0,  2'b11, 1'b1, 32'h12345678);
    issue_exp("mul_lsl7",      32'h12345678, 7,  2'b00, 1'b1, 32'h12345678);
    issue_exp("ror_5",         32'hFFFF0000, 5,  2'b11, 1'b0, 32'h07FFF800);
    issue_exp("ror_4",         32'hF000000F, 4,  2'b11, 1'b0, 32'hFF000000);
    issue_exp("ror_0",         32'hF000000F, 0,  2'b11, 1'b0, 32'hF000000F);
    issue_exp("lsl_31",        32'hFFFFFFFF, 31, 2'b00, 1'b0, 32'h80000000);
    issue_exp("lsr_31",        32'h80000001, 31, 2'b01, 1'b0, 32'h00000001);
    issue_exp("asr_31_neg",    32'h80000000, 31, 2'b10, 1'b0, 32'hFFFFFFFF);
    issue_exp("asr_31_pos",    32'h7FFFFFFF, 31, 2'b10, 1'b0, 32'h00000000);
    issue_exp("lsl_0",         32'hDEADBEEF, 0,  2'b00, 1'b0, 32'hDEADBEEF);
    issue_exp("asr_0",         32'hDEADBEEF, 0,  2'b10, 1'b0, 32'hDEADBEEF);
    issue_exp("ror_31",        32'h00000001, 31, 2'b11, 1'b0, 32'h00000002);
    drain();

    // Back-to-back random traffic: every cycle carries a new operation.
    for (int i = 0; i < 400; i++) begin
      logic m;
      m = ($urandom_range(0, 7) == 0);
      issue("random", $urandom(), $urandom_range(0, 31), 2'($urandom_range(0, 3)), m);
    end
    drain();

    // Asynchronous reset asserted while holding a live result.
    issue("pre_reset", 32'hA5A5A5A5, 0, 2'b00, 1'b1);
    drain();
    @(posedge clk);
    #2;
    check("hold_before_reset", data, 32'hA5A5A5A5);
    rst_n = 1'b0;
    #1;
    check("async_reset_mid_cycle", data, '0);
    @(posedge clk);
    #1;
    check("reset_dominates_clk", data, '0);
    @(negedge clk);
    rst_n = 1'b1;
    issue_exp("after_reset", 32'h0000F00D, 8, 2'b00, 1'b0, 32'h00F00D00);
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/shifter.md
Name: shifter

Overview:
Operand-2 shifter for the processor datapath. It applies LSL, LSR, ASR or ROR to the register operand rd2 by an immediate shift amount. When the instruction is a multiply, it passes rd2 through unshifted. The result is registered and feeds the ALU B-input mux.

Parameters:
- WIDTH, 32, data width of rd2/data.
- SHAMT_W, 5, width of shift_amount; must equal clog2(WIDTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- shift_amount  input  SHAMT_W  shift distance, 0..WIDTH-1.
- shift_type  input  2  00=LSL, 01=LSR, 10=ASR, 11=ROR.
- mul  input  1  1 = multiply instruction; bypass the shifter.
- rd2  input  WIDTH  operand to shift.
- data  output  WIDTH  registered shifted operand.

Behaviour:
- Reset: when rst_n is low, data = 0 immediately, without waiting for a clock edge. Release is synchronous to the next clk edge.
- Latency: exactly 1 cycle. The inputs sampled at rising edge N appear on data after edge N and hold until edge N+1. No handshake; a new operation is accepted every cycle.
- Next-state function:
  - mul=1: data_next = rd2, regardless of shift_type and shift_amount. mul has priority over everything else.
  - mul=0, 00 LSL: rd2 << shift_amount, zero fill.
  - mul=0, 01 LSR: rd2 >> shift_amount, zero fill.
  - mul=0, 10 ASR: arithmetic right shift; vacated bits are filled with rd2[WIDTH-1].
  - mul=0, 11 ROR: (rd2 >> sh) | (rd2 << (WIDTH-sh)).
- ROR boundary: when sh=0, the ROR result is rd2. The implementation must not shift by WIDTH or produce X.
- shift_amount=0: all types return rd2 unchanged.
- shift_amount=WIDTH-1 (31):
  - LSL keeps only bit 0, moved to the MSB.
  - LSR keeps only the MSB, moved to bit 0.
  - ASR yields all-ones or all-zeros, depending on rd2[31].
- Arithmetic is width-preserving: no carry-out, no flags.
- X on inputs is don't-care. The reset value takes precedence over any input activity.
- Implementation: a log2 barrel shifter (5 mux stages for WIDTH=32). Do not use a single variable-shift operator per type, so that timing is balanced. Right shifts and rotates share one stage chain with a selectable fill source (zero, sign, or wrapped bits). LSL is done by bit-reversing the input and output around the same chain.

Decomposition:
- Package shifter_pkg:
  - enum shift_type_e {SH_LSL=2'b00, SH_LSR=2'b01, SH_ASR=2'b10, SH_ROR=2'b11}.
  - WIDTH/SHAMT_W default constants.
- Sub-module shifter_core: purely combinational barrel-shift network (rd2, shift_amount, shift_type → result).
- Top level shifter: holds the mul bypass mux and the output register with async reset.

Test Plan:
- Reset: hold rst_n=0 with arbitrary inputs → data=00000000. The output clears asynchronously, before any clk edge, including when reset is asserted mid-stream.
- LSL: rd2=000000FF, amt=2, type=00, mul=0 → data=000003FC one cycle later.
- LSR and ASR (check the fill rule):
  - rd2=F000000F, amt=3, type=01 → 1E000001.
  - rd2=80000000, amt=4, type=10 → F8000000.
  - rd2=7F000000, amt=4, type=10 → 07F00000.
- Multiply bypass: rd2=12345678, amt=0, type=11, mul=1 → 12345678. Repeat with amt=7, type=00 → still 12345678.
- ROR: rd2=FFFF0000, amt=5, type=11 → 07FFF800. rd2=F000000F, amt=4 → FF000000. amt=0 → rd2 unchanged.
- Extremes and throughput:
  - rd2=FFFFFFFF, amt=31, LSL → 80000000.
  - Back-to-back different ops on consecutive cycles → each result appears exactly 1 cycle after its inputs, with no bubbles.
